// File: rtl/nco_sweep_pkg.sv
// Shared types and defaults for the NCO frequency-sweep controller.
package nco_sweep_pkg;

  localparam int PHI_W_DEF   = 16;
  localparam int DWELL_W_DEF = 16;
  localparam logic [15:0] HOP_IDX_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_DWELL,
    ST_STEP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Controller-to-NCO link: phase increment and clock enable out, sample valid back.
interface nco_sweep_ctrl_if
  import nco_sweep_pkg::*;
#(
  parameter int PHI_W = PHI_W_DEF
);
  logic [PHI_W-1:0] phi_inc_o;
  logic             nco_clken_o;
  logic             nco_valid_i;

  modport master (output phi_inc_o, output nco_clken_o, input nco_valid_i);
  modport slave  (input phi_inc_o, input nco_clken_o, output nco_valid_i);
endinterface

// File: rtl/nco_dwell_cnt.sv
// Down-counter for valid NCO samples within one hop; load wins over enable.
module nco_dwell_cnt #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped phase-increment sweep FSM driving an NCO, dwelling a fixed number of valid samples per hop.
// Optional build macro NCO_SWEEP_PINGPONG_EN: continuous mode bounces between bounds instead of sawtooth.
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int PHI_W   = PHI_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [PHI_W-1:0]   cfg_start_inc,
  input  logic [PHI_W-1:0]   cfg_stop_inc,
  input  logic [PHI_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_continuous,
  nco_sweep_ctrl_if.master   nco,
  output logic [15:0]        hop_idx,
  output logic               busy,
  output logic               done
);

  function automatic logic [15:0] sat_inc(input logic [15:0] h);
    return (h == HOP_IDX_MAX) ? h : h + 16'd1;
  endfunction

  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  state_t             state;
  logic [PHI_W-1:0]   phi_q;
  logic               clken_q;
  logic [PHI_W-1:0]   start_q;
  logic [PHI_W-1:0]   stop_q;
  logic [PHI_W-1:0]   step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;

  // One extra bit so a sum past the top of the range never aliases below stop.
  logic [PHI_W:0] nxt_up;
  logic           up_ok;
  assign nxt_up = {1'b0, phi_q} + {1'b0, step_q};
  assign up_ok  = (nxt_up <= {1'b0, stop_q}) && (step_q != '0);

`ifdef NCO_SWEEP_PINGPONG_EN
  logic           dir_down;
  logic [PHI_W:0] nxt_dn;
  logic           dn_ok;
  assign nxt_dn = {1'b0, phi_q} - {1'b0, step_q};
  assign dn_ok  = !nxt_dn[PHI_W] && (nxt_dn[PHI_W-1:0] >= start_q);
`endif

  logic cnt_load;
  logic cnt_en;
  logic cnt_zero;

  assign cnt_load = !abort &&
                    (((state == ST_PRIME) && nco.nco_valid_i) || (state == ST_STEP));
  assign cnt_en   = (state == ST_DWELL) && nco.nco_valid_i;

  nco_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (dwell_reload(dwell_q)),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      phi_q    <= '0;
      hop_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      clken_q  <= 1'b0;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
`ifdef NCO_SWEEP_PINGPONG_EN
      dir_down <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        clken_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              start_q  <= cfg_start_inc;
              stop_q   <= cfg_stop_inc;
              step_q   <= cfg_step;
              dwell_q  <= cfg_dwell;
              cont_q   <= cfg_continuous;
              phi_q    <= cfg_start_inc;
              hop_idx  <= '0;
              busy     <= 1'b1;
              clken_q  <= 1'b1;
`ifdef NCO_SWEEP_PINGPONG_EN
              dir_down <= 1'b0;
`endif
              state    <= ST_PRIME;
            end
          end
          ST_PRIME: begin
            if (nco.nco_valid_i) state <= ST_DWELL;
          end
          ST_DWELL: begin
            if (nco.nco_valid_i && cnt_zero) state <= ST_STEP;
          end
          ST_STEP: begin
`ifdef NCO_SWEEP_PINGPONG_EN
            if (dir_down) begin
              if (dn_ok) begin
                phi_q <= nxt_dn[PHI_W-1:0];
              end else begin
                dir_down <= 1'b0;
                phi_q    <= nxt_up[PHI_W-1:0];
              end
              hop_idx <= sat_inc(hop_idx);
              state   <= ST_DWELL;
            end else
`endif
            if (up_ok) begin
              phi_q   <= nxt_up[PHI_W-1:0];
              hop_idx <= sat_inc(hop_idx);
              state   <= ST_DWELL;
            end else if (cont_q) begin
`ifdef NCO_SWEEP_PINGPONG_EN
              dir_down <= 1'b1;
              phi_q    <= nxt_dn[PHI_W-1:0];
`else
              phi_q    <= start_q;
`endif
              hop_idx <= sat_inc(hop_idx);
              state   <= ST_DWELL;
            end else begin
              done    <= 1'b1;
              clken_q <= 1'b0;
              state   <= ST_DONE;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy    <= 1'b0;
            clken_q <= 1'b0;
            state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign nco.phi_inc_o   = phi_q;
  assign nco.nco_clken_o = clken_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: hand-computed per-cycle output vectors.
module tb_nco_sweep_ctrl;

  localparam int PHI_W   = 16;
  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [PHI_W-1:0]   cfg_start_inc = '0;
  logic [PHI_W-1:0]   cfg_stop_inc = '0;
  logic [PHI_W-1:0]   cfg_step = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic               cfg_continuous = 1'b0;
  logic [15:0]        hop_idx;
  logic               busy;
  logic               done;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] seq [6];

  nco_sweep_ctrl_if #(.PHI_W(PHI_W)) nco_bus ();

  nco_sweep_ctrl #(.PHI_W(PHI_W), .DWELL_W(DWELL_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .cfg_start_inc  (cfg_start_inc),
    .cfg_stop_inc   (cfg_stop_inc),
    .cfg_step       (cfg_step),
    .cfg_dwell      (cfg_dwell),
    .cfg_continuous (cfg_continuous),
    .nco            (nco_bus),
    .hop_idx        (hop_idx),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of run, expected $finish before 200us");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] phi, input logic [15:0] hop,
                            input logic b, input logic c, input logic d);
    logic [34:0] obs;
    logic [34:0] exp;
    obs = {nco_bus.phi_inc_o, hop_idx, busy, nco_bus.nco_clken_o, done};
    exp = {phi, hop, b, c, d};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed phi=%h hop=%h busy/clken/done=%b, expected phi=%h hop=%h busy/clken/done=%b",
             tag, obs[34:19], obs[18:3], obs[2:0], exp[34:19], exp[18:3], exp[2:0]);
    end
  endtask

  task automatic step_expect(input string tag, input logic [15:0] phi, input logic [15:0] hop,
                             input logic b, input logic c, input logic d);
    tick();
    expect_out(tag, phi, hop, b, c, d);
  endtask

  task automatic hold_expect(input string tag, input int n, input logic [15:0] phi,
                             input logic [15:0] hop, input logic b, input logic c, input logic d);
    for (int i = 0; i < n; i++) step_expect(tag, phi, hop, b, c, d);
  endtask

  task automatic set_cfg(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                         input logic [15:0] dw, input logic cont);
    cfg_start_inc  = s;
    cfg_stop_inc   = e;
    cfg_step       = st;
    cfg_dwell      = dw;
    cfg_continuous = cont;
  endtask

  // 100..400 step 100, dwell 4; valid arrives on the third PRIME cycle.
  task automatic sweep_basic();
    set_cfg(16'd100, 16'd400, 16'd100, 16'd4, 1'b0);
    nco_bus.nco_valid_i = 1'b0;
    start = 1'b1;
    step_expect("basic_start", 16'd100, 16'd0, 1, 1, 0);
    start = 1'b0;
    set_cfg(16'h1234, 16'hFFFF, 16'd1, 16'd1, 1'b1);
    hold_expect("basic_prime", 2, 16'd100, 16'd0, 1, 1, 0);
    nco_bus.nco_valid_i = 1'b1;
    hold_expect("basic_hop0", 5, 16'd100, 16'd0, 1, 1, 0);
    hold_expect("basic_hop1", 5, 16'd200, 16'd1, 1, 1, 0);
    hold_expect("basic_hop2", 5, 16'd300, 16'd2, 1, 1, 0);
    hold_expect("basic_hop3", 5, 16'd400, 16'd3, 1, 1, 0);
    step_expect("basic_done", 16'd400, 16'd3, 1, 0, 1);
    hold_expect("basic_idle", 2, 16'd400, 16'd3, 0, 0, 0);
  endtask

  initial begin
`ifdef NCO_SWEEP_PINGPONG_EN
    seq[0] = 16'd10; seq[1] = 16'd20; seq[2] = 16'd30;
    seq[3] = 16'd20; seq[4] = 16'd10; seq[5] = 16'd20;
`else
    seq[0] = 16'd10; seq[1] = 16'd20; seq[2] = 16'd30;
    seq[3] = 16'd10; seq[4] = 16'd20; seq[5] = 16'd30;
`endif
    nco_bus.nco_valid_i = 1'b0;

    // reset state
    reset_n = 1'b0;
    set_cfg(16'h5555, 16'hAAAA, 16'd3, 16'd7, 1'b1);
    start = 1'b1;
    hold_expect("reset", 2, 16'd0, 16'd0, 0, 0, 0);
    start = 1'b0;
    reset_n = 1'b1;
    step_expect("reset_release", 16'd0, 16'd0, 0, 0, 0);

    sweep_basic();

    // valid gated for 5 cycles mid-dwell, plus an ignored start during dwell
    set_cfg(16'd100, 16'd200, 16'd100, 16'd4, 1'b0);
    nco_bus.nco_valid_i = 1'b1;
    start = 1'b1;
    step_expect("gate_start", 16'd100, 16'd0, 1, 1, 0);
    start = 1'b0;
    hold_expect("gate_dwell", 2, 16'd100, 16'd0, 1, 1, 0);
    nco_bus.nco_valid_i = 1'b0;
    set_cfg(16'h0777, 16'hFFFF, 16'd1, 16'd1, 1'b1);
    start = 1'b1;
    step_expect("gate_start_ignored", 16'd100, 16'd0, 1, 1, 0);
    start = 1'b0;
    hold_expect("gate_frozen", 4, 16'd100, 16'd0, 1, 1, 0);
    nco_bus.nco_valid_i = 1'b1;
    hold_expect("gate_resume", 3, 16'd100, 16'd0, 1, 1, 0);
    hold_expect("gate_hop1", 5, 16'd200, 16'd1, 1, 1, 0);
    step_expect("gate_done", 16'd200, 16'd1, 1, 0, 1);
    step_expect("gate_idle", 16'd200, 16'd1, 0, 0, 0);

    // top-of-range: no wrap; dwell=0 acts as 1
    set_cfg(16'hFF00, 16'hFFFF, 16'h0200, 16'd0, 1'b0);
    start = 1'b1;
    step_expect("wrap_start", 16'hFF00, 16'd0, 1, 1, 0);
    start = 1'b0;
    hold_expect("wrap_dwell", 2, 16'hFF00, 16'd0, 1, 1, 0);
    step_expect("wrap_done", 16'hFF00, 16'd0, 1, 0, 1);
    step_expect("wrap_idle", 16'hFF00, 16'd0, 0, 0, 0);

    // start above stop: exactly one dwell
    set_cfg(16'd500, 16'd100, 16'd50, 16'd2, 1'b0);
    start = 1'b1;
    step_expect("inv_start", 16'd500, 16'd0, 1, 1, 0);
    start = 1'b0;
    hold_expect("inv_dwell", 3, 16'd500, 16'd0, 1, 1, 0);
    step_expect("inv_done", 16'd500, 16'd0, 1, 0, 1);
    step_expect("inv_idle", 16'd500, 16'd0, 0, 0, 0);

    // continuous 10..30 step 10 dwell 1, then abort
    set_cfg(16'd10, 16'd30, 16'd10, 16'd1, 1'b1);
    start = 1'b1;
    step_expect("cont_start", seq[0], 16'd0, 1, 1, 0);
    start = 1'b0;
    hold_expect("cont_hop0", 2, seq[0], 16'd0, 1, 1, 0);
    for (int k = 1; k < 5; k++) hold_expect("cont_hop", 2, seq[k], k[15:0], 1, 1, 0);
    step_expect("cont_hop5", seq[5], 16'd5, 1, 1, 0);
    abort = 1'b1;
    step_expect("cont_abort", seq[5], 16'd5, 0, 0, 0);
    abort = 1'b0;
    step_expect("cont_abort_idle", seq[5], 16'd5, 0, 0, 0);

    // start together with abort in idle
    set_cfg(16'd100, 16'd400, 16'd100, 16'd4, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    step_expect("start_abort", seq[5], 16'd5, 0, 0, 0);
    start = 1'b0;
    abort = 1'b0;
    step_expect("start_abort_idle", seq[5], 16'd5, 0, 0, 0);

    // reset while in STEP, then a normal sweep
    set_cfg(16'd100, 16'd400, 16'd100, 16'd4, 1'b0);
    nco_bus.nco_valid_i = 1'b1;
    start = 1'b1;
    step_expect("rst_start", 16'd100, 16'd0, 1, 1, 0);
    start = 1'b0;
    hold_expect("rst_run", 5, 16'd100, 16'd0, 1, 1, 0);
    reset_n = 1'b0;
    step_expect("rst_in_step", 16'd0, 16'd0, 0, 0, 0);
    reset_n = 1'b1;
    step_expect("rst_after", 16'd0, 16'd0, 0, 0, 0);
    sweep_basic();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter PHI_W, default 16, phase-increment width matching the NCO phi_inc_i port.
REQ-002 SHALL have parameter DWELL_W, default 16, dwell-counter width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that latches config and starts a sweep.
REQ-006 SHALL have port abort  input  1  pulse that stops any sweep immediately.
REQ-007 SHALL have port cfg_start_inc  input  PHI_W  first phase increment.
REQ-008 SHALL have port cfg_stop_inc  input  PHI_W  upper bound of the sweep.
REQ-009 SHALL have port cfg_step  input  PHI_W  increment added per hop.
REQ-010 SHALL have port cfg_dwell  input  DWELL_W  valid NCO samples per hop; 0 is treated as 1.
REQ-011 SHALL have port cfg_continuous  input  1  0 = one sweep then done, 1 = repeat until abort.
REQ-012 SHALL have port nco_valid_i  input  1  NCO out_valid.
REQ-013 SHALL have port phi_inc_o  output  PHI_W  drives NCO phi_inc_i.
REQ-014 SHALL have port nco_clken_o  output  1  drives NCO clken.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-017 SHALL have port hop_idx  output  16  number of hops since start, saturating at 0xFFFF.

Function
REQ-018 SHALL implement the states IDLE, PRIME, DWELL, STEP and DONE.
REQ-019 IDLE: on start, SHALL latch all cfg_* inputs, set phi_inc_o=cfg_start_inc and hop_idx=0, then go to PRIME; cfg_* changes after start SHALL have no effect.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 nco_clken_o SHALL be 1 in PRIME, DWELL and STEP, and 0 in IDLE and DONE.
REQ-022 PRIME: SHALL wait for nco_valid_i=1 (NCO pipeline fill), then load the dwell counter with max(cfg_dwell,1)-1 and go to DWELL.
REQ-023 DWELL: SHALL decrement the counter only on cycles with nco_valid_i=1; a valid cycle with counter=0 SHALL go to STEP.
REQ-024 STEP (one cycle): SHALL compute nxt = cur + cfg_step in PHI_W+1 bits.
REQ-025 If nxt <= cfg_stop_inc and cfg_step != 0, STEP SHALL load phi_inc_o=nxt, increment hop_idx, reload the dwell counter and go to DWELL.
REQ-026 Otherwise (end of sweep), STEP SHALL go to DONE if cfg_continuous=0, or reload phi_inc_o=cfg_start_inc, increment hop_idx, reload the dwell counter and go to DWELL if cfg_continuous=1.
REQ-027 The PHI_W+1 compare SHALL prevent wrap-around; cfg_start_inc > cfg_stop_inc SHALL give exactly one dwell at cfg_start_inc.
REQ-028 DONE: SHALL assert done for one cycle and return to IDLE; phi_inc_o and hop_idx SHALL hold their last values.
REQ-029 abort SHALL take priority over all transitions and start: next state IDLE, no done pulse, phi_inc_o held.
REQ-030 phi_inc_o SHALL change only on STEP exit or on start, so every dwell sees a constant increment.

Reset
REQ-031 On reset_n=0 at a clk edge, the block SHALL enter IDLE with phi_inc_o=0, nco_clken_o=0, busy=0, done=0, hop_idx=0, dwell counter=0 and latched config=0.
REQ-032 Reset mid-sweep SHALL behave as in REQ-031, with no done pulse.

Configuration
REQ-033 With NCO_SWEEP_PINGPONG_EN defined, continuous mode SHALL reverse direction at the bounds instead of reloading: on the way up, nxt > stop sets direction down and loads cur-step; on the way down, cur-step < start (borrow-checked) sets direction up and loads cur+step; the direction register resets to up.
REQ-034 Without NCO_SWEEP_PINGPONG_EN, continuous mode SHALL be a sawtooth (REQ-026), and no direction register SHALL exist.

Structure
REQ-035 A shared package nco_sweep_pkg SHALL hold the state enum, PHI_W/DWELL_W defaults and the HOP_IDX_MAX constant.
REQ-036 The dwell counter SHALL be the single sub-module nco_dwell_cnt (load, enable, zero flag); all else SHALL be in the top FSM.

Verification
REQ-037 Reset, then start with start=100, stop=400, step=100, dwell=4, single mode, valid=1 from cycle 3 -> phi_inc_o = 100, 200, 300, 400 for 4 valid cycles each, hop_idx=3, one done pulse, nco_clken_o=0 after.
REQ-038 Gate nco_valid_i low for 5 cycles mid-DWELL -> the counter freezes and the hop lengthens by exactly 5 cycles.
REQ-039 start=0xFF00, step=0x0200, stop=0xFFFF -> one dwell at 0xFF00, then done; no wrap to 0x0100.
REQ-040 Continuous mode with start=10, stop=30, step=10 -> sequence 10, 20, 30, 10 (sawtooth), or 10, 20, 30, 20, 10, 20 with NCO_SWEEP_PINGPONG_EN; abort -> IDLE next cycle, no done.
REQ-041 start together with abort in IDLE -> stays IDLE; start during DWELL -> ignored, latched config unchanged.
REQ-042 reset_n=0 during STEP -> all outputs at reset values next cycle; a following start behaves as in REQ-037.
